// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared types and helpers for the UART transmitter
// Rev 1.0
// ============================================================================
package uart_pkg;

  localparam int C_MAX_DWIDTH = 9;

  typedef enum logic [1:0] {
    PAR_NONE  = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE2 = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_MARK   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_e;

  // Parity is taken over data bits only; unused upper bits must be zero.
  function automatic logic par_bit(input logic [C_MAX_DWIDTH-1:0] data, input parity_e mode);
    case (mode)
      PAR_ODD:  par_bit = ~^data;
      PAR_EVEN: par_bit = ^data;
      default:  par_bit = 1'b0;
    endcase
  endfunction

  function automatic logic par_en(input parity_e mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
// uart_baud_gen : down-counter producing one bit_tick every max(div,1) clocks
// Rev 1.0
// ============================================================================
module uart_baud_gen #(
  parameter int DIVW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic [DIVW-1:0] div,
  output logic            bit_tick
);

  logic [DIVW-1:0] cnt_q, cnt_d, reload;

  // Reload with div-1 so the tick lands on the last clock of each bit.
  always_comb begin
    reload = (div == '0) ? '0 : div - DIVW'(1);
    cnt_d  = cnt_q - DIVW'(1);
    if (clear || (cnt_q == '0)) cnt_d = reload;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign bit_tick = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo_baud.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo_baud : AXI4-Stream fed UART transmitter with FIFO, baud divider,
// runtime parity, 1/2 stop bits and optional mark bit.
// Rev 1.0
// ============================================================================
module uart_tx_fifo_baud
  import uart_pkg::*;
#(
  parameter int  DWIDTH    = 8,
  parameter int  DEPTH     = 4,
  parameter int  DIVW      = 16,
  parameter int  TLAST_BIT = 0,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic              uart_clk,
  input  logic              uart_rst_n,
  input  logic [DWIDTH-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic [DIVW-1:0]   cfg_baud_div,
  input  logic [1:0]        cfg_parity,
  input  logic              cfg_stop2,
  output logic              uart_txd,
  output logic              uart_busy,
  output logic              tx_done,
  output logic [LW-1:0]     tx_level
);

  localparam int AW  = $clog2(DEPTH);
  localparam int FW  = DWIDTH + 1;
  localparam int BCW = 4;

  logic [FW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              push, pop, load, fifo_empty;
  logic [DWIDTH-1:0] head_data;
  logic              head_last;
  logic [C_MAX_DWIDTH-1:0] head_ext;
  parity_e           par_mode;

  tx_state_e         state_q, state_d;
  logic [DWIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DIVW-1:0]   div_q, div_d;
  logic              mark_q, mark_d, par_val_q, par_val_d, par_en_q, par_en_d;
  logic              stop2_q, stop2_d, txd_q, txd_d, done_q, done_d;
  logic              bit_tick;

  assign fifo_empty    = (level_q == '0);
  assign s_axis_tready = (level_q != LW'(DEPTH));
  assign push          = s_axis_tvalid && s_axis_tready;
  assign head_data     = mem_q[rd_ptr_q][DWIDTH-1:0];
  assign head_last     = mem_q[rd_ptr_q][DWIDTH];
  assign par_mode      = parity_e'(cfg_parity);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge uart_clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
  end

  // The divider restarts on every frame load so the start bit is full length.
  uart_baud_gen #(.DIVW(DIVW)) u_baud (
    .clk      (uart_clk),
    .rst_n    (uart_rst_n),
    .clear    (load),
    .div      (load ? cfg_baud_div : div_q),
    .bit_tick (bit_tick)
  );

  always_comb begin
    head_ext             = '0;
    head_ext[DWIDTH-1:0] = head_data;
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_d     = div_q;
    mark_d    = mark_q;
    par_val_d = par_val_q;
    par_en_d  = par_en_q;
    stop2_d   = stop2_q;
    done_d    = 1'b0;
    load      = 1'b0;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE:  load = !fifo_empty;
      ST_START: if (bit_tick) begin
        state_d   = ST_DATA;
        bit_cnt_d = '0;
      end
      ST_DATA: if (bit_tick) begin
        shreg_d   = shreg_q >> 1;
        bit_cnt_d = bit_cnt_q + BCW'(1);
        if (bit_cnt_q == BCW'(DWIDTH - 1)) begin
          bit_cnt_d = '0;
          if (TLAST_BIT != 0) state_d = ST_MARK;
          else if (par_en_q)  state_d = ST_PARITY;
          else                state_d = ST_STOP;
        end
      end
      ST_MARK:   if (bit_tick) state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_tick) state_d = ST_STOP;
      ST_STOP: if (bit_tick) begin
        if (stop2_q && (bit_cnt_q == '0)) begin
          bit_cnt_d = BCW'(1);
        end else begin
          done_d = 1'b1;
          if (!fifo_empty) load = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d   = ST_START;
      pop       = 1'b1;
      shreg_d   = head_data;
      mark_d    = head_last;
      div_d     = cfg_baud_div;
      par_en_d  = par_en(par_mode);
      par_val_d = par_bit(head_ext, par_mode);
      stop2_d   = cfg_stop2;
    end

    // Line level is a function of the next state so txd stays a plain flop.
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shreg_d[0];
      ST_MARK:   txd_d = mark_d;
      ST_PARITY: txd_d = par_val_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge uart_clk or negedge uart_rst_n) begin
    if (!uart_rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= '0;
      mark_q    <= 1'b0;
      par_val_q <= 1'b0;
      par_en_q  <= 1'b0;
      stop2_q   <= 1'b0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      mark_q    <= mark_d;
      par_val_q <= par_val_d;
      par_en_q  <= par_en_d;
      stop2_q   <= stop2_d;
      txd_q     <= txd_d;
      done_q    <= done_d;
    end
  end

  assign uart_txd  = txd_q;
  assign tx_done   = done_q;
  assign tx_level  = level_q;
  assign uart_busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule
`default_nettype wire
